// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and codes for the multicycle controller: FSM states, ALU control and condition codes.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Evaluate a condition field against NZCV flags.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = !z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = !c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = !n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = !v;
      COND_HI: cond_eval = c & !z;
      COND_LS: cond_eval = !c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = !z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_unit.sv
// Condition check plus the NZCV flags register and the per-instruction condition latch.
module cond_unit
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       flag_upd,
  input  logic       cond_upd,
  output logic       cond_ex_r,
  output logic [3:0] flags
);

  // Condition is latched leaving DECODE so later flag updates cannot change gating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags     <= 4'b0000;
      cond_ex_r <= 1'b0;
    end else begin
      if (cond_upd) cond_ex_r <= cond_eval(cond, flags);
      if (flag_upd && cond_ex_r) begin
        if (flag_w[1]) flags[3:2] <= alu_flags[3:2];
        if (flag_w[0]) flags[1:0] <= alu_flags[1:0];
      end
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control: main FSM, ALU decode and condition-gated write enables.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       next_pc, reg_w, mem_w, branch, alu_op;
  logic [1:0] flag_w;
  logic       cond_ex_r;
  logic [3:0] flags;
  logic       pcs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and raw per-state controls.
  always_comb begin
    state_d   = S_FETCH;
    IRWrite   = 1'b0;
    next_pc   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    reg_w     = 1'b0;
    mem_w     = 1'b0;
    branch    = 1'b0;
    alu_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        state_d   = S_DECODE;
        IRWrite   = 1'b1;
        next_pc   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        case (Op)
          2'b01:   state_d = S_MEMADR;
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        state_d = Funct[0] ? S_MEMRD : S_MEMWR;
        ALUSrcB = 2'b01;
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_w     = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1;
        mem_w  = 1'b1;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
        alu_op  = 1'b1;
      end
      S_EXECI: begin
        state_d = S_ALUWB;
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation and flag-write decode from the command field.
  always_comb begin
    ALUControl = ALU_ADD;
    flag_w     = 2'b00;
    if (alu_op) begin
      case (Funct[4:1])
        4'b0100: ALUControl = ALU_ADD;
        4'b0010: ALUControl = ALU_SUB;
        4'b0000: ALUControl = ALU_AND;
        4'b1100: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      flag_w[1] = Funct[0];
      flag_w[0] = Funct[0] & ((ALUControl == ALU_ADD) || (ALUControl == ALU_SUB));
    end
  end

  cond_unit u_cond (
    .clk       (clk),
    .reset     (reset),
    .cond      (Cond),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .flag_upd  (alu_op),
    .cond_upd  (state_q == S_DECODE),
    .cond_ex_r (cond_ex_r),
    .flags     (flags)
  );

  assign ImmSrc   = Op;
  assign RegSrc   = {Op == 2'b01, Op == 2'b10};
  assign pcs      = branch | (reg_w & (Rd == 4'b1111));
  assign PCWrite  = next_pc | (pcs & cond_ex_r);
  assign RegWrite = reg_w & cond_ex_r;
  assign MemWrite = mem_w & cond_ex_r;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd, Cond, ALUFlags;
  logic       PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd), .Cond(Cond),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                       input logic [3:0] cnd, input logic [3:0] af);
    Op = op; Funct = fn; Rd = rd; Cond = cnd; ALUFlags = af;
  endtask

  initial begin
    reset = 1'b1;
    instr(2'b11, 6'b0, 4'b0, COND_AL, 4'b0);
    #2;
    check("rst_state", 8'(state), 8'(S_FETCH));
    check("rst_irwrite", 8'(IRWrite), 8'd1);
    check("rst_pcwrite", 8'(PCWrite), 8'd1);
    check("rst_flags", 8'(dut.u_cond.flags), 8'h0);
    tick;
    check("rst_hold_state", 8'(state), 8'(S_FETCH));
    #3 reset = 1'b0;

    // ADD r3 (register form, no S)
    @(negedge clk);
    instr(2'b00, 6'b001000, 4'd3, COND_AL, 4'b1111);
    #1;
    check("add_fetch_state", 8'(state), 8'(S_FETCH));
    check("add_fetch_srcb", 8'(ALUSrcB), 8'b10);
    check("add_fetch_res", 8'(ResultSrc), 8'b10);
    check("add_fetch_srca", 8'(ALUSrcA), 8'd1);
    check("add_fetch_regw", 8'(RegWrite), 8'd0);
    tick;
    check("add_dec_state", 8'(state), 8'(S_DECODE));
    check("add_dec_pcw", 8'(PCWrite), 8'd0);
    check("add_dec_irw", 8'(IRWrite), 8'd0);
    tick;
    check("add_exec_state", 8'(state), 8'(S_EXECR));
    check("add_exec_aluc", 8'(ALUControl), 8'(ALU_ADD));
    check("add_exec_regw", 8'(RegWrite), 8'd0);
    tick;
    check("add_wb_state", 8'(state), 8'(S_ALUWB));
    check("add_wb_regw", 8'(RegWrite), 8'd1);
    check("add_wb_pcw", 8'(PCWrite), 8'd0);
    tick;
    check("add_end_state", 8'(state), 8'(S_FETCH));
    check("add_flags", 8'(dut.u_cond.flags), 8'h0);

    // LDR r2
    instr(2'b01, 6'b011001, 4'd2, COND_AL, 4'b0);
    tick;
    check("ldr_dec_state", 8'(state), 8'(S_DECODE));
    check("ldr_immsrc", 8'(ImmSrc), 8'b01);
    check("ldr_regsrc", 8'(RegSrc), 8'b10);
    tick;
    check("ldr_adr_state", 8'(state), 8'(S_MEMADR));
    check("ldr_adr_srcb", 8'(ALUSrcB), 8'b01);
    tick;
    check("ldr_rd_state", 8'(state), 8'(S_MEMRD));
    check("ldr_rd_adrsrc", 8'(AdrSrc), 8'd1);
    check("ldr_rd_regw", 8'(RegWrite), 8'd0);
    tick;
    check("ldr_wb_state", 8'(state), 8'(S_MEMWB));
    check("ldr_wb_regw", 8'(RegWrite), 8'd1);
    check("ldr_wb_res", 8'(ResultSrc), 8'b01);
    tick;
    check("ldr_end_state", 8'(state), 8'(S_FETCH));

    // SUBS r1 with ALU reporting Z
    instr(2'b00, 6'b000101, 4'd1, COND_AL, 4'b0100);
    tick; tick;
    check("subs_exec_state", 8'(state), 8'(S_EXECR));
    check("subs_aluc", 8'(ALUControl), 8'(ALU_SUB));
    tick;
    check("subs_flags", 8'(dut.u_cond.flags), 8'b0100);
    tick;

    // BEQ taken
    instr(2'b10, 6'b000000, 4'd0, COND_EQ, 4'b0);
    tick;
    check("beq_regsrc", 8'(RegSrc), 8'b01);
    tick;
    check("beq_state", 8'(state), 8'(S_BRANCH));
    check("beq_pcw", 8'(PCWrite), 8'd1);
    check("beq_srcb", 8'(ALUSrcB), 8'b01);
    tick;
    check("beq_end_state", 8'(state), 8'(S_FETCH));

    // BNE not taken
    instr(2'b10, 6'b000000, 4'd0, COND_NE, 4'b0);
    tick; tick;
    check("bne_state", 8'(state), 8'(S_BRANCH));
    check("bne_pcw", 8'(PCWrite), 8'd0);
    tick;

    // STRNE with Z=1: full sequence, no memory write
    instr(2'b01, 6'b011000, 4'd4, COND_NE, 4'b0);
    check("strne_fetch_memw", 8'(MemWrite), 8'd0);
    tick;
    check("strne_dec_memw", 8'(MemWrite), 8'd0);
    tick;
    check("strne_adr_state", 8'(state), 8'(S_MEMADR));
    tick;
    check("strne_wr_state", 8'(state), 8'(S_MEMWR));
    check("strne_wr_memw", 8'(MemWrite), 8'd0);
    check("strne_wr_adrsrc", 8'(AdrSrc), 8'd1);
    tick;
    check("strne_end_state", 8'(state), 8'(S_FETCH));

    // STR always: memory write asserted
    instr(2'b01, 6'b011000, 4'd4, COND_AL, 4'b0);
    tick; tick; tick;
    check("str_wr_memw", 8'(MemWrite), 8'd1);
    tick;

    // ADD pc, AL: PC written in ALUWB
    instr(2'b00, 6'b001000, 4'd15, COND_AL, 4'b0);
    tick; tick; tick;
    check("addpc_state", 8'(state), 8'(S_ALUWB));
    check("addpc_pcw", 8'(PCWrite), 8'd1);
    tick;

    // Op=11: decode straight back to fetch
    instr(2'b11, 6'b000000, 4'd15, COND_AL, 4'b0);
    tick;
    check("op3_dec_regw", 8'(RegWrite), 8'd0);
    check("op3_dec_memw", 8'(MemWrite), 8'd0);
    tick;
    check("op3_end_state", 8'(state), 8'(S_FETCH));

    // ORR immediate
    instr(2'b00, 6'b111000, 4'd5, COND_AL, 4'b0);
    tick; tick;
    check("orri_state", 8'(state), 8'(S_EXECI));
    check("orri_aluc", 8'(ALUControl), 8'(ALU_ORR));
    check("orri_srcb", 8'(ALUSrcB), 8'b01);
    tick; tick;

    // SUBSNE with Z=1: no flag update, no reg write, same length
    instr(2'b00, 6'b000101, 4'd1, COND_NE, 4'b0011);
    tick; tick;
    check("subsne_exec_state", 8'(state), 8'(S_EXECR));
    tick;
    check("subsne_wb_state", 8'(state), 8'(S_ALUWB));
    check("subsne_regw", 8'(RegWrite), 8'd0);
    check("subsne_flags", 8'(dut.u_cond.flags), 8'b0100);
    tick;
    check("subsne_end_state", 8'(state), 8'(S_FETCH));

    // ANDS: only N and Z written
    instr(2'b00, 6'b000001, 4'd6, COND_AL, 4'b1010);
    tick; tick;
    check("ands_aluc", 8'(ALUControl), 8'(ALU_AND));
    tick;
    check("ands_flags", 8'(dut.u_cond.flags), 8'b1000);
    tick;

    // Reset in MEMRD of an LDR
    instr(2'b01, 6'b011001, 4'd2, COND_AL, 4'b0);
    tick; tick; tick;
    check("rldr_rd_state", 8'(state), 8'(S_MEMRD));
    #2 reset = 1'b1;
    #1;
    check("rldr_async_state", 8'(state), 8'(S_FETCH));
    check("rldr_async_flags", 8'(dut.u_cond.flags), 8'h0);
    check("rldr_async_regw", 8'(RegWrite), 8'd0);
    instr(2'b11, 6'b000000, 4'd2, COND_AL, 4'b0);
    tick;
    check("rldr_hold_state", 8'(state), 8'(S_FETCH));
    check("rldr_hold_pcw", 8'(PCWrite), 8'd1);
    check("rldr_hold_irw", 8'(IRWrite), 8'd1);
    #3 reset = 1'b0;
    tick;
    check("rldr_post_state", 8'(state), 8'(S_DECODE));
    check("rldr_post_regw", 8'(RegWrite), 8'd0);
    tick;
    check("rldr_post2_state", 8'(state), 8'(S_FETCH));
    check("rldr_post2_regw", 8'(RegWrite), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
